dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_if.sv | 32 +++
 rtl/dmem_ctrl.sv | 127 ++++++++++++
 tb/tb_dmem_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Pipeline-side and memory-bus-side signals of the data memory controller.
// The master modport is the controller; the slave modport is its environment.
interface dmem_ctrl_if;
    logic [31:0] address;
    logic [31:0] data_write;
    logic [1:0]  size;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_mem;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        misalign_err;
    logic        timeout_err;

    modport master (
        input  address, data_write, size, mem_read, mem_write, bus_ack, bus_rdata,
        output data_mem, stall, bus_req, bus_we, bus_addr, bus_wdata, bus_be,
               misalign_err, timeout_err
    );

    modport slave (
        output address, data_write, size, mem_read, mem_write, bus_ack, bus_rdata,
        input  data_mem, stall, bus_req, bus_we, bus_addr, bus_wdata, bus_be,
               misalign_err, timeout_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data memory controller: one byte/half/word access per IDLE->BUSY->DONE pass.
// Define DMEM_TIMEOUT_EN to abort a BUSY access after 255 cycles without ack.
module dmem_ctrl (
    input logic         clk,
    input logic         rst,
    dmem_ctrl_if.master mem
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, next_state;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        latch_en, capture_en, timeout_hit;
    logic        access, misaligned, in_half, in_word;
    logic        q_byte, q_half;
    logic [31:0] rd_shifted;

    assign access     = mem.mem_read | mem.mem_write;
    assign in_half    = (mem.size == 2'b01);
    assign in_word    = (mem.size == 2'b00) || (mem.size == 2'b11);
    assign misaligned = (in_half && mem.address[0]) || (in_word && (mem.address[1:0] != 2'b00));

    assign q_byte     = (size_q == 2'b10);
    assign q_half     = (size_q == 2'b01);
    assign rd_shifted = q_byte ? (mem.bus_rdata >> {addr_q[1:0], 3'b000}) & 32'h0000_00FF :
                        q_half ? (mem.bus_rdata >> {addr_q[1], 4'b0000}) & 32'h0000_FFFF :
                                 mem.bus_rdata;

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (latch_en)
            cnt <= '0;
        else if (state == BUSY)
            cnt <= cnt + 8'd1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= next_state;
            if (latch_en) begin
                addr_q  <= mem.address;
                wdata_q <= mem.data_write;
                size_q  <= mem.size;
                we_q    <= mem.mem_write;
            end
            if (capture_en)
                rdata_q <= we_q ? '0 : rd_shifted;
            else if (timeout_hit)
                rdata_q <= '0;
        end
    end

    always_comb begin
        next_state       = state;
        latch_en         = 1'b0;
        capture_en       = 1'b0;
        timeout_hit      = 1'b0;
        mem.stall        = 1'b0;
        mem.bus_req      = 1'b0;
        mem.bus_we       = 1'b0;
        mem.bus_addr     = '0;
        mem.bus_be       = '0;
        mem.bus_wdata    = '0;
        mem.data_mem     = '0;
        mem.misalign_err = 1'b0;
        mem.timeout_err  = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        mem.misalign_err = 1'b1;
                    end else begin
                        mem.stall  = 1'b1;
                        latch_en   = 1'b1;
                        next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                mem.stall    = 1'b1;
                mem.bus_req  = 1'b1;
                mem.bus_we   = we_q;
                mem.bus_addr = {addr_q[31:2], 2'b00};
                if (q_byte) begin
                    mem.bus_be    = 4'b0001 << addr_q[1:0];
                    mem.bus_wdata = {4{wdata_q[7:0]}};
                end else if (q_half) begin
                    mem.bus_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    mem.bus_wdata = {2{wdata_q[15:0]}};
                end else begin
                    mem.bus_be    = 4'b1111;
                    mem.bus_wdata = wdata_q;
                end
                if (mem.bus_ack) begin
                    capture_en = 1'b1;
                    next_state = DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                // An ack arriving in the final counted cycle still wins over the timeout.
                else if (cnt == 8'hFF) begin
                    mem.bus_req     = 1'b0;
                    mem.timeout_err = 1'b1;
                    timeout_hit     = 1'b1;
                    next_state      = DONE;
                end
`endif
            end
            DONE: begin
                mem.data_mem = rdata_q;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed, table-driven bench for dmem_ctrl plus hand sequences for reset and wait corners.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks = 0;
    int unsigned failures = 0;

    dmem_ctrl_if mif();

    dmem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .mem (mif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned waits;
        logic        mis;
        logic [31:0] eaddr;
        logic [3:0]  ebe;
        logic [31:0] ewdata;
        logic        ewe;
        logic [31:0] edata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mif.mem_read   = 1'b0;
        mif.mem_write  = 1'b0;
        mif.address    = '0;
        mif.data_write = '0;
        mif.size       = '0;
        mif.bus_ack    = 1'b0;
        mif.bus_rdata  = '0;
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        mif.mem_read   = v.rd;
        mif.mem_write  = v.wr;
        mif.size       = v.size;
        mif.address    = v.addr;
        mif.data_write = v.wdata;
        mif.bus_ack    = 1'b0;
        mif.bus_rdata  = v.rdata;
        @(negedge clk);
        if (v.mis) begin
            chk("mis_err", {31'b0, mif.misalign_err}, 32'd1);
            chk("mis_stall", {31'b0, mif.stall}, 32'd0);
            chk("mis_req", {31'b0, mif.bus_req}, 32'd0);
            chk("mis_data", mif.data_mem, 32'd0);
            @(posedge clk); #1;
            mif.mem_read  = 1'b0;
            mif.mem_write = 1'b0;
            @(negedge clk);
            chk("mis_pulse_end", {31'b0, mif.misalign_err}, 32'd0);
            chk("mis_stay_idle", {30'b0, mif.bus_req, mif.stall}, 32'd0);
            return;
        end
        chk("idle_stall", {31'b0, mif.stall}, 32'd1);
        chk("idle_req", {31'b0, mif.bus_req}, 32'd0);
        chk("idle_mis", {31'b0, mif.misalign_err}, 32'd0);
        for (int unsigned w = 0; w <= v.waits; w++) begin
            @(posedge clk); #1;
            if (w == 0) begin
                // Input changes during BUSY must not disturb the latched request.
                mif.mem_read   = 1'b0;
                mif.mem_write  = ~v.wr;
                mif.address    = ~v.addr;
                mif.data_write = ~v.wdata;
                mif.size       = ~v.size;
            end
            mif.bus_ack = (w == v.waits);
            @(negedge clk);
            chk("busy_req", {31'b0, mif.bus_req}, 32'd1);
            chk("busy_stall", {31'b0, mif.stall}, 32'd1);
            chk("busy_addr", mif.bus_addr, v.eaddr);
            chk("busy_be", {28'b0, mif.bus_be}, {28'b0, v.ebe});
            chk("busy_wdata", mif.bus_wdata, v.ewdata);
            chk("busy_we", {31'b0, mif.bus_we}, {31'b0, v.ewe});
        end
        @(posedge clk); #1;
        idle_inputs();
        mif.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("done_stall", {31'b0, mif.stall}, 32'd0);
        chk("done_req", {31'b0, mif.bus_req}, 32'd0);
        chk("done_data", mif.data_mem, v.edata);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_stall", {31'b0, mif.stall}, 32'd0);
        chk("after_data", mif.data_mem, 32'd0);
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int unsigned waits,
                                input logic mis, input logic [31:0] eaddr,
                                input logic [3:0] ebe, input logic [31:0] ewdata,
                                input logic ewe, input logic [31:0] edata);
        vec_t v;
        v.wr = wr; v.rd = rd; v.size = size; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.waits = waits; v.mis = mis; v.eaddr = eaddr;
        v.ebe = ebe; v.ewdata = ewdata; v.ewe = ewe; v.edata = edata;
        return v;
    endfunction

    initial begin
        int unsigned reqs;
        logic        ok;

        //          wr    rd    size   addr          wdata         rdata         wt mis eaddr         be       ewdata        we    edata
        vecs[0]  = mk(1'b0, 1'b1, 2'b00, 32'h0000_0100, 32'h0,        32'h1234_5678, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        1'b0, 32'h1234_5678);
        vecs[1]  = mk(1'b1, 1'b0, 2'b10, 32'h0000_0203, 32'h0000_00AB, 32'h5555_5555, 1, 0, 32'h0000_0200, 4'b1000, 32'hABAB_ABAB, 1'b1, 32'h0);
        vecs[2]  = mk(1'b0, 1'b1, 2'b01, 32'h0000_0102, 32'h0,        32'hBEEF_0000, 4, 0, 32'h0000_0100, 4'b1100, 32'h0,        1'b0, 32'h0000_BEEF);
        vecs[3]  = mk(1'b0, 1'b1, 2'b00, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[4]  = mk(1'b0, 1'b1, 2'b10, 32'h0000_0301, 32'h0,        32'h1122_3344, 0, 0, 32'h0000_0300, 4'b0010, 32'h0,        1'b0, 32'h0000_0033);
        vecs[5]  = mk(1'b1, 1'b0, 2'b01, 32'h0000_0400, 32'hFFFF_1234, 32'h0,        2, 0, 32'h0000_0400, 4'b0011, 32'h1234_1234, 1'b1, 32'h0);
        vecs[6]  = mk(1'b1, 1'b1, 2'b00, 32'h0000_0500, 32'hCAFE_F00D, 32'h9999_9999, 0, 0, 32'h0000_0500, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0);
        vecs[7]  = mk(1'b0, 1'b1, 2'b01, 32'h0000_0103, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[8]  = mk(1'b0, 1'b1, 2'b10, 32'h0000_0000, 32'h0,        32'hAABB_CCDD, 1, 0, 32'h0000_0000, 4'b0001, 32'h0,        1'b0, 32'h0000_00DD);
        vecs[9]  = mk(1'b0, 1'b1, 2'b11, 32'h0000_0008, 32'h0,        32'h0BAD_F00D, 2, 0, 32'h0000_0008, 4'b1111, 32'h0,        1'b0, 32'h0BAD_F00D);
        vecs[10] = mk(1'b0, 1'b1, 2'b01, 32'h0000_0201, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[11] = mk(1'b1, 1'b0, 2'b10, 32'h0000_0007, 32'h0000_005A, 32'h0,        0, 0, 32'h0000_0004, 4'b1000, 32'h5A5A_5A5A, 1'b1, 32'h0);

        idle_inputs();
        rst = 1'b1;
        #12;
        chk("rst_req", {31'b0, mif.bus_req}, 32'd0);
        chk("rst_stall", {31'b0, mif.stall}, 32'd0);
        chk("rst_addr", mif.bus_addr, 32'd0);
        chk("rst_be", {28'b0, mif.bus_be}, 32'd0);
        chk("rst_wdata", mif.bus_wdata, 32'd0);
        chk("rst_data", mif.data_mem, 32'd0);
        chk("rst_errs", {30'b0, mif.misalign_err, mif.timeout_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Stray ack while idle must be ignored.
        @(posedge clk); #1;
        mif.bus_ack = 1'b1;
        @(negedge clk);
        chk("stray_ack_idle", {30'b0, mif.bus_req, mif.stall}, 32'd0);
        @(posedge clk); #1;
        mif.bus_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_after", {30'b0, mif.bus_req, mif.stall}, 32'd0);

        for (int i = 0; i < 12; i++)
            run_vec(vecs[i]);

        // Reset in the second BUSY cycle aborts the access without replay.
        @(posedge clk); #1;
        mif.mem_read = 1'b1;
        mif.size     = 2'b00;
        mif.address  = 32'h0000_0600;
        @(posedge clk); #1;
        mif.mem_read = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_busy", {31'b0, mif.bus_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_req", {31'b0, mif.bus_req}, 32'd0);
        chk("midrst_stall", {31'b0, mif.stall}, 32'd0);
        chk("midrst_addr", mif.bus_addr, 32'd0);
        chk("midrst_be", {28'b0, mif.bus_be}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("no_replay", {30'b0, mif.bus_req, mif.stall}, 32'd0);
        run_vec(vecs[0]);

`ifdef DMEM_TIMEOUT_EN
        @(posedge clk); #1;
        mif.mem_read = 1'b1;
        mif.address  = 32'h0000_0700;
        mif.size     = 2'b00;
        @(posedge clk); #1;
        mif.mem_read = 1'b0;
        reqs = 0;
        ok   = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (mif.timeout_err) begin
                ok = 1'b1;
                break;
            end
            if (mif.bus_req) reqs++;
            @(posedge clk); #1;
        end
        chk("timeout_seen", {31'b0, ok}, 32'd1);
        chk("timeout_busy_cycles", reqs, 32'd255);
        chk("timeout_req_drop", {31'b0, mif.bus_req}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("timeout_done_data", mif.data_mem, 32'd0);
        chk("timeout_done_stall", {31'b0, mif.stall}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("timeout_idle", {30'b0, mif.bus_req, mif.stall}, 32'd0);
`else
        // Without the timeout build, BUSY holds indefinitely until ack.
        @(posedge clk); #1;
        mif.mem_read = 1'b1;
        mif.address  = 32'h0000_0700;
        mif.size     = 2'b00;
        @(posedge clk); #1;
        mif.mem_read = 1'b0;
        ok   = 1'b1;
        reqs = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!mif.bus_req || !mif.stall || mif.timeout_err) ok = 1'b0;
            reqs++;
            @(posedge clk); #1;
        end
        chk("no_timeout_hold", {31'b0, ok}, 32'd1);
        mif.bus_ack   = 1'b1;
        mif.bus_rdata = 32'h7777_0001;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("no_timeout_done", mif.data_mem, 32'h7777_0001);
        chk("no_timeout_err", {31'b0, mif.timeout_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
